// File: rtl/datapath_wbus_pkg.sv
// Shared widths and opcode constants for the W-bus datapath and its sequencer.
package datapath_wbus_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

endpackage

// File: rtl/datapath_wbus_alu.sv
// Combinational adder/subtractor; subtract is a + ~b + 1 so carry=1 means no borrow.
module adder_subtractor
  import datapath_wbus_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b ^ {W{sub}}} + (W+1)'(sub);
    result = sum[W-1:0];
    carry  = sum[W];
  end

endmodule

// File: rtl/datapath_wbus.sv
// W-bus datapath: PC, MAR, program RAM, IR, ACC, B, OUT and an ALU sharing one bus.
// Define DATAPATH_FLAGS_EN to add carry/zero flag outputs updated on La&Eu.
module datapath_wbus
  import datapath_wbus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lm,
  input  logic              CE,
  input  logic              Li,
  input  logic              Ei,
  input  logic              La,
  input  logic              Ea,
  input  logic              Su,
  input  logic              Eu,
  input  logic              Lb,
  input  logic              Lo,
  input  logic              hlt,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic [DATA_W-1:0] out_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              bus_err
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic              carry,
  output logic              zero
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, b_q, b_d, out_q, out_d;
  logic              halted_q, halted_d, bus_err_q, bus_err_d;
  logic [DATA_W-1:0] ram_q [2**ADDR_W];

  logic [DATA_W-1:0] bus, ram_rd, alu_result;
  logic [2:0]        n_en;
  logic              bus_conflict, active, ram_we;

  assign ram_rd = ram_q[mar_q];

`ifdef DATAPATH_FLAGS_EN
  logic alu_carry;
  logic carry_q, carry_d, zero_q, zero_d;

  adder_subtractor #(.W(DATA_W)) u_alu (
    .a(acc_q), .b(b_q), .sub(Su), .result(alu_result), .carry(alu_carry)
  );
`else
  adder_subtractor #(.W(DATA_W)) u_alu (
    .a(acc_q), .b(b_q), .sub(Su), .result(alu_result), .carry()
  );
`endif

  // Contention drives 0 rather than a wired-OR so a bad control word is visible as a clean zero.
  always_comb begin
    n_en         = 3'(Ep) + 3'(CE) + 3'(Ei) + 3'(Ea) + 3'(Eu);
    bus_conflict = (n_en > 3'd1);
    bus          = '0;
    if (!bus_conflict) begin
      if (Ep)      bus = DATA_W'(pc_q);
      else if (CE) bus = ram_rd;
      else if (Ei) bus = DATA_W'(ir_q[3:0]);
      else if (Ea) bus = acc_q;
      else if (Eu) bus = alu_result;
    end
  end

  always_comb begin
    active    = !prog_mode && !halted_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    b_d       = b_q;
    out_d     = out_q;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
`ifdef DATAPATH_FLAGS_EN
    carry_d   = carry_q;
    zero_d    = zero_q;
`endif
    if (active) begin
      if (Cp)  pc_d     = pc_q + ADDR_W'(1);
      if (Lm)  mar_d    = bus[ADDR_W-1:0];
      if (Li)  ir_d     = bus;
      if (La)  acc_d    = bus;
      if (Lb)  b_d      = bus;
      if (Lo)  out_d    = bus;
      if (hlt) halted_d = 1'b1;
`ifdef DATAPATH_FLAGS_EN
      if (La && Eu) begin
        carry_d = alu_carry;
        zero_d  = (alu_result == '0);
      end
`endif
    end
    if (!prog_mode && bus_conflict) bus_err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      out_q     <= '0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      out_q     <= out_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

  // RAM survives clr, but a write coinciding with clr is suppressed.
  assign ram_we = prog_mode && prog_we && !clr;

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[prog_addr] <= prog_data;
  end

  assign instruction = ir_q[7:4];
  assign out_reg     = out_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_datapath_wbus.sv
// Directed bench for datapath_wbus: program run, PC wrap, bus contention, subtract, clr and halt behaviour.
module tb_datapath_wbus;
  import datapath_wbus_pkg::*;

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic       Cp = 0, Ep = 0, Lm = 0, CE = 0, Li = 0, Ei = 0, La = 0, Ea = 0;
  logic       Su = 0, Eu = 0, Lb = 0, Lo = 0, hlt = 0;
  logic       prog_mode = 0, prog_we = 0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] instruction;
  logic [7:0] out_reg;
  logic [3:0] pc;
  logic       halted, bus_err;
`ifdef DATAPATH_FLAGS_EN
  logic       carry, zero;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [12:0] C_CP = 13'h1000, C_EP = 13'h0800, C_LM = 13'h0400, C_CE = 13'h0200;
  localparam logic [12:0] C_LI = 13'h0100, C_EI = 13'h0080, C_LA = 13'h0040, C_EA = 13'h0020;
  localparam logic [12:0] C_SU = 13'h0010, C_EU = 13'h0008, C_LB = 13'h0004, C_LO = 13'h0002;
  localparam logic [12:0] C_HLT = 13'h0001;

  int         p_addr [10] = '{0, 1, 2, 3, 4, 9, 10, 11, 12, 13};
  logic [7:0] p_data [10] = '{{LDA, 4'h9}, {ADD, 4'hA}, {SUB, 4'hB}, {OUT, 4'h0}, {HLT, 4'h0},
                              8'd16, 8'd20, 8'd12, 8'h05, 8'h07};

  datapath_wbus dut (
    .clock(clock), .clr(clr),
    .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La), .Ea(Ea),
    .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .hlt(hlt),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .out_reg(out_reg), .pc(pc), .halted(halted), .bus_err(bus_err)
`ifdef DATAPATH_FLAGS_EN
    , .carry(carry), .zero(zero)
`endif
  );

  always #5 clock = ~clock;

  task automatic set_ctl(input logic [12:0] w);
    {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt} = w;
  endtask

  task automatic cyc(input logic [12:0] w);
    set_ctl(w);
    @(posedge clock);
    #1;
    set_ctl('0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #3;
    clr = 1'b0;
  endtask

  task automatic fetch();
    cyc(C_EP | C_LM);
    cyc(C_CP);
    cyc(C_CE | C_LI);
  endtask

  initial begin
    int cur;
    repeat (2) @(posedge clock);
    #1;
    clr = 1'b0;
    check("rst_pc", 32'(pc), 0);
    check("rst_out", 32'(out_reg), 0);
    check("rst_instr", 32'(instruction), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_bus_err", 32'(bus_err), 0);

    // Load RAM with Cp held high: prog_mode must freeze the PC.
    prog_mode = 1'b1;
    prog_we   = 1'b1;
    Cp        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prog_addr = 4'(p_addr[i]);
      prog_data = p_data[i];
      @(posedge clock);
      #1;
    end
    prog_we   = 1'b0;
    prog_mode = 1'b0;
    Cp        = 1'b0;
    check("prog_freeze_pc", 32'(pc), 0);

    prog_we   = 1'b1;
    prog_addr = 4'd9;
    prog_data = 8'h55;
    cyc('0);
    prog_we   = 1'b0;

    // Program: LDA 9; ADD A; SUB B; OUT; HLT  -> 16 + 20 - 12 = 24
    fetch();
    check("fetch_lda_opcode", 32'(instruction), 32'(LDA));
    cyc(C_EI | C_LM);
    cyc(C_CE | C_LA);
    fetch();
    cyc(C_EI | C_LM);
    cyc(C_CE | C_LB);
    cyc(C_EU | C_LA);
    fetch();
    cyc(C_EI | C_LM);
    cyc(C_CE | C_LB);
    cyc(C_SU | C_EU | C_LA);
    fetch();
    check("fetch_out_opcode", 32'(instruction), 32'(OUT));
    cyc(C_EA | C_LO);
    fetch();
    cyc(C_HLT);
    check("prog_out", 32'(out_reg), 24);
    check("prog_halted", 32'(halted), 1);
    check("prog_pc", 32'(pc), 5);
    check("prog_bus_err", 32'(bus_err), 0);
`ifdef DATAPATH_FLAGS_EN
    check("prog_carry", 32'(carry), 1);
    check("prog_zero", 32'(zero), 0);
`endif

    // Cp with Ep: MAR takes the old PC, PC still increments.
    do_clr();
    cyc(C_CP);
    cyc(C_CP);
    cyc(C_CP | C_EP | C_LM);
    check("cp_ep_pc", 32'(pc), 3);
    cyc(C_CE | C_LA);
    cyc(C_EA | C_LO);
    check("cp_ep_mar", 32'(out_reg), 32'h2B);

    // PC wrap.
    do_clr();
    repeat (15) cyc(C_CP);
    check("pc_15", 32'(pc), 15);
    cyc(C_CP);
    check("pc_wrap", 32'(pc), 0);
    cyc(C_CP);
    check("pc_17", 32'(pc), 1);

    // Bus contention.
    do_clr();
    cyc(C_CE | C_LA);
    cyc(C_EA | C_LO);
    check("acc_load", 32'(out_reg), 32'h09);
    check("bus_err_clear", 32'(bus_err), 0);
    cyc(C_EA | C_CE | C_LO);
    check("conflict_bus", 32'(out_reg), 0);
    check("conflict_err", 32'(bus_err), 1);
    repeat (3) cyc('0);
    check("conflict_sticky", 32'(bus_err), 1);
    do_clr();
    check("conflict_clr", 32'(bus_err), 0);

    // 0x05 - 0x07 = 0xFE with a borrow.
    do_clr();
    repeat (12) cyc(C_CP);
    cyc(C_EP | C_LM);
    cyc(C_CE | C_LA);
    cyc(C_CP);
    cyc(C_EP | C_LM);
    cyc(C_CE | C_LB);
    cyc(C_SU | C_EU | C_LA);
    cyc(C_EA | C_LO);
    check("sub_result", 32'(out_reg), 32'hFE);
`ifdef DATAPATH_FLAGS_EN
    check("sub_carry", 32'(carry), 0);
    check("sub_zero", 32'(zero), 0);
`endif

    // Asynchronous clr mid-cycle with loads, Cp and a RAM write pending.
    set_ctl(C_CE | C_LA | C_CP | C_LO);
    #2;
    clr = 1'b1;
    #1;
    check("clr_async_pc", 32'(pc), 0);
    check("clr_async_out", 32'(out_reg), 0);
    check("clr_async_instr", 32'(instruction), 0);
    check("clr_async_halted", 32'(halted), 0);
    @(posedge clock);
    #1;
    check("clr_hold_pc", 32'(pc), 0);
    check("clr_hold_out", 32'(out_reg), 0);
    set_ctl('0);
    prog_mode = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 8'hAA;
    @(posedge clock);
    #1;
    prog_we   = 1'b0;
    prog_mode = 1'b0;
    clr       = 1'b0;
    cyc(C_EA | C_LO);
    check("clr_acc", 32'(out_reg), 0);

    // RAM readback after clr.
    do_clr();
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      while (cur < p_addr[i]) begin
        cyc(C_CP);
        cur++;
      end
      cyc(C_EP | C_LM);
      cyc(C_CE | C_LO);
      check($sformatf("ram_readback_%0d", p_addr[i]), 32'(out_reg), 32'(p_data[i]));
    end

    // hlt with Lo: OUT loads on that edge, then everything freezes.
    do_clr();
    repeat (3) cyc(C_CP);
    cyc(C_EP | C_LM);
    cyc(C_CE | C_LA);
    cyc(C_EA | C_LO | C_HLT);
    check("hlt_out", 32'(out_reg), 32'hE0);
    check("hlt_halted", 32'(halted), 1);
    cyc(C_CP);
    check("hlt_cp_ignored", 32'(pc), 3);
    cyc(C_CE | C_LI);
    check("hlt_li_ignored", 32'(instruction), 0);
    cyc(C_EP | C_LO);
    check("hlt_lo_ignored", 32'(out_reg), 32'hE0);
    cyc(C_SU | C_EU | C_LA);
    cyc(C_EA | C_LO);
    check("hlt_la_ignored", 32'(out_reg), 32'hE0);
    check("hlt_sticky", 32'(halted), 1);
    do_clr();
    check("hlt_clr", 32'(halted), 0);
    cyc(C_CP);
    check("post_clr_cp", 32'(pc), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
